// File: rtl/dcache_qspi_seq.sv
// dcache_qspi_seq: data-cache miss sequencer, dirty write-back then line fill over QSPI PSRAM
module dcache_qspi_seq #(
  parameter int LINE_LENGTH = 4,
  parameter int PA = 22,
  parameter int WAIT_CYCLES = 6,
  parameter int CS_GAP = 2,
  parameter logic [7:0] CMD_READ = 8'hEB,
  parameter logic [7:0] CMD_WRITE = 8'h38
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_op,
  input  logic fault,
  input  logic hit,
  input  logic push,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] tag,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] victim_tag,
  input  logic [3:0] dwrite,
  output logic [3:0] dread,
  output logic wstrobe_d,
  output logic rstrobe_d,
  output logic stall,
  output logic done,
  output logic spi_cs_n,
  output logic spi_sck_en,
  output logic spi_oe,
  output logic [3:0] spi_io_out,
  input  logic [3:0] spi_io_in
);
  localparam int LB = $clog2(LINE_LENGTH);
  // WB_* and RD_* phases are consecutive so a phase advances by incrementing the state
  typedef enum logic [3:0] {
    IDLE, WB_CMD, WB_ADDR, WB_DATA, WB_GAP, RD_CMD, RD_ADDR, RD_WAIT, RD_DATA, DONE
  } state_t;
  state_t state, nxt;
  logic [7:0] cnt, len;
  logic [PA-LB-1:0] tag_q, victim_q;
  logic [23:0] addr, addr_sh;
  logic miss, last, active, drive;
  always_comb begin
    miss = mem_op & !hit & !fault;
    len = (state == WB_CMD || state == RD_CMD) ? 8'd2 :
          (state == WB_ADDR || state == RD_ADDR) ? 8'd6 :
          (state == WB_DATA || state == RD_DATA) ? 8'(2 * LINE_LENGTH) :
          state == RD_WAIT ? 8'(WAIT_CYCLES) : 8'(CS_GAP);
    last = cnt == len - 8'd1;
    nxt = state == IDLE ? (miss ? (push ? WB_CMD : RD_CMD) : IDLE) :
          !last ? state :
          state == WB_GAP ? RD_CMD :
          state == DONE ? IDLE : state_t'(state + 4'd1);
    active = nxt inside {WB_CMD, WB_ADDR, WB_DATA, RD_CMD, RD_ADDR, RD_WAIT, RD_DATA};
    drive = nxt inside {WB_CMD, WB_ADDR, WB_DATA, RD_CMD, RD_ADDR};
    addr = 24'({state == WB_ADDR ? victim_q : tag_q, {LB{1'b0}}});
    addr_sh = addr << {cnt[2:0], 2'b00};
    spi_io_out = state == WB_CMD ? (cnt[0] ? CMD_WRITE[3:0] : CMD_WRITE[7:4]) :
                 state == RD_CMD ? (cnt[0] ? CMD_READ[3:0] : CMD_READ[7:4]) :
                 (state == WB_ADDR || state == RD_ADDR) ? addr_sh[23:20] :
                 state == WB_DATA ? dwrite : 4'h0;
    rstrobe_d = state == WB_DATA;
    done = state == DONE && last;
    stall = state != IDLE || miss;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      tag_q <= '0;
      victim_q <= '0;
      spi_cs_n <= 1'b1;
      spi_sck_en <= 1'b0;
      spi_oe <= 1'b0;
      wstrobe_d <= 1'b0;
      dread <= 4'h0;
    end else begin
      state <= nxt;
      cnt <= (state == IDLE || last) ? 8'd0 : cnt + 8'd1;
      if (state == IDLE && miss) begin
        tag_q <= tag;
        victim_q <= victim_tag;
      end
      spi_cs_n <= !active;
      spi_sck_en <= active;
      spi_oe <= drive;
      wstrobe_d <= state == RD_DATA;
      if (state == RD_DATA) dread <= spi_io_in;
    end
  end
endmodule

// File: tb/tb_dcache_qspi_seq.sv
// tb_dcache_qspi_seq: phase-list reference waveform plus cache-side model around dcache_qspi_seq
module tb_dcache_qspi_seq;
  localparam int LL = 4, PA = 22, LB = 2, W = 6, G = 2, NN = 2 * LL;
  logic clk = 1'b0, reset, mem_op, fault, hit, push;
  logic [PA-LB-1:0] tag, victim_tag;
  logic [3:0] dwrite, dread, spi_io_out, spi_io_in;
  logic wstrobe_d, rstrobe_d, stall, done, spi_cs_n, spi_sck_en, spi_oe;
  int checks = 0, passes = 0;

  dcache_qspi_seq dut (
    .clk(clk), .reset(reset), .mem_op(mem_op), .fault(fault), .hit(hit), .push(push),
    .tag(tag), .victim_tag(victim_tag), .dwrite(dwrite), .dread(dread),
    .wstrobe_d(wstrobe_d), .rstrobe_d(rstrobe_d), .stall(stall), .done(done),
    .spi_cs_n(spi_cs_n), .spi_sck_en(spi_sck_en), .spi_oe(spi_oe),
    .spi_io_out(spi_io_out), .spi_io_in(spi_io_in)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // chip-select high time before every falling edge
  int hi_run = 100;
  logic prev_cs = 1'b1;
  always @(negedge clk) begin
    if (reset) hi_run = 100;
    else if (spi_cs_n) hi_run++;
    else begin
      if (prev_cs) check("cs_n gap", 32'(hi_run >= G), 32'd1);
      hi_run = 0;
    end
    prev_cs = spi_cs_n;
  end

  typedef struct {
    logic cs_n, oe, rs, ws, done, stall, rd;
    logic [3:0] io;
  } cyc_t;
  cyc_t q[$];

  function automatic void put(logic cs_n, logic oe, logic rs, logic rd, logic dn, int io);
    cyc_t c;
    c.cs_n = cs_n; c.oe = oe; c.rs = rs; c.rd = rd; c.done = dn; c.stall = 1'b1;
    c.io = 4'(io);
    c.ws = q.size() > 0 && q[q.size()-1].rd;
    q.push_back(c);
  endfunction

  // expected cycle list from the transaction's phase sequence, cycle 0 = miss detect
  function automatic void build(logic pu, int tg, int vt, logic [31:0] wl);
    int a;
    q.delete();
    put(1, 0, 0, 0, 0, 0);
    if (pu) begin
      a = vt * LL;
      for (int i = 0; i < 2; i++) put(0, 1, 0, 0, 0, (32'h38 >> (4 * (1 - i))) & 15);
      for (int i = 0; i < 6; i++) put(0, 1, 0, 0, 0, (a >> (4 * (5 - i))) & 15);
      for (int i = 0; i < NN; i++) put(0, 1, 1, 0, 0, int'(wl >> (4 * i)) & 15);
      for (int i = 0; i < G; i++) put(1, 0, 0, 0, 0, 0);
    end
    a = tg * LL;
    for (int i = 0; i < 2; i++) put(0, 1, 0, 0, 0, (32'hEB >> (4 * (1 - i))) & 15);
    for (int i = 0; i < 6; i++) put(0, 1, 0, 0, 0, (a >> (4 * (5 - i))) & 15);
    for (int i = 0; i < W; i++) put(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NN; i++) put(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < G; i++) put(1, 0, 0, 0, i == G - 1, 0);
    put(1, 0, 0, 0, 0, 0);
    q[q.size()-1].stall = 1'b0;
  endfunction

  typedef struct {
    logic pu;
    logic [19:0] tg, vt;
    logic [31:0] wl, rl;
    int exp_done;
  } vec_t;
  vec_t vt[6];

  task automatic run_tx(vec_t v, int idx);
    int off = 0, rxo = 0, rdi = 0, done_at = -1, last;
    logic [31:0] rx = 0;
    logic [10:0] act, exp;
    build(v.pu, int'(v.tg), int'(v.vt), v.wl);
    last = q.size() - 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      mem_op = (k == 0 || k == last) ? 1'b1 : 1'($urandom_range(0, 1));
      hit = k == 0 ? 1'b0 : k == last ? 1'b1 : 1'($urandom_range(0, 1));
      fault = (k == 0 || k == last) ? 1'b0 : 1'($urandom_range(0, 1));
      push = k == 0 ? v.pu : 1'($urandom_range(0, 1));
      tag = k == 0 ? v.tg : 20'($urandom);
      victim_tag = k == 0 ? v.vt : 20'($urandom);
      dwrite = 4'(v.wl >> (4 * (off % NN)));
      if (q[k].rd) begin
        spi_io_in = 4'(v.rl >> (4 * rdi));
        rdi++;
      end else spi_io_in = 4'($urandom_range(0, 15));
      #1;
      act = {spi_cs_n, spi_sck_en, spi_oe, spi_oe ? spi_io_out : 4'h0, rstrobe_d, wstrobe_d, done, stall};
      exp = {q[k].cs_n, !q[k].cs_n, q[k].oe, q[k].io, q[k].rs, q[k].ws, q[k].done, q[k].stall};
      check($sformatf("tx%0d cyc%0d {cs_n,sck,oe,io,rs,ws,done,stall}", idx, k), 32'(act), 32'(exp));
      off = rstrobe_d ? off + 1 : 0;
      if (wstrobe_d) begin
        if (rxo < NN) rx[4*rxo +: 4] = dread;
        rxo++;
      end else rxo = 0;
      if (done) done_at = k;
    end
    check($sformatf("tx%0d fill line", idx), rx, v.rl);
    check($sformatf("tx%0d done cycle", idx), 32'(done_at), 32'(v.exp_done));
  endtask

  initial begin
    int dn;
    reset = 1'b1; mem_op = 1'b0; fault = 1'b0; hit = 1'b0; push = 1'b0;
    tag = '0; victim_tag = '0; dwrite = 4'h0; spi_io_in = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset outputs {cs_n,sck,oe,rs,ws,done,stall,dread}",
          32'({spi_cs_n, spi_sck_en, spi_oe, rstrobe_d, wstrobe_d, done, stall, dread}),
          32'({7'b1000000, 4'h0}));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_op = 1'b1; hit = i >= 4; fault = i < 4; tag = 20'($urandom);
      #1;
      check($sformatf("no-miss %0d {stall,cs_n}", i), 32'({stall, spi_cs_n}), 32'b01);
    end
    vt[0] = '{1'b0, 20'h01234, 20'h00000, 32'h0, 32'h89ABCDEF, 24};
    vt[1] = '{1'b1, 20'h00AAA, 20'h00005, 32'h76543210, 32'h0F1E2D3C, 42};
    for (int i = 2; i < 6; i++) begin
      vt[i].pu = 1'($urandom_range(0, 1));
      vt[i].tg = 20'($urandom);
      vt[i].vt = 20'($urandom);
      vt[i].wl = $urandom;
      vt[i].rl = $urandom;
      vt[i].exp_done = vt[i].pu ? 42 : 24;
    end
    for (int i = 0; i < 6; i++) run_tx(vt[i], i);
    // reset during RD_DATA nibble 3 of a clean miss (cycle 18)
    for (int k = 0; k <= 19; k++) begin
      @(negedge clk);
      mem_op = k == 0; hit = 1'b0; fault = 1'b0; push = 1'b0; tag = 20'h00777;
      spi_io_in = 4'($urandom_range(0, 15));
      reset = k == 18;
    end
    #1;
    check("post-reset {cs_n,sck,oe,rs,ws,done,stall}",
          32'({spi_cs_n, spi_sck_en, spi_oe, rstrobe_d, wstrobe_d, done, stall}), 32'b1000000);
    dn = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      mem_op = 1'b0;
      #1;
      dn += int'(done) + int'(!spi_cs_n);
    end
    check("no done/cs after reset", 32'(dn), 32'd0);
    run_tx(vt[0], 6);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
